// File: rtl/rs_multi_cdb.sv
// rs_multi_cdb: reservation station for non-memory operations.
//   SIZE = 1<<BITS entries sit between the issue stage and the ALU. Source
//   operands that are still in flight wake up from any of CDB_N result
//   broadcast channels. Both the issue side and the ALU side use valid/ready
//   handshakes. An entry is freed at the clock edge where the ALU accepts it.
//
// Configuration macro: RS_OLDEST_FIRST_EN
//   defined   - dispatch the eligible entry whose tag is oldest relative to rob_head
//   undefined - dispatch the lowest-index eligible entry (rob_head unused)
//
// Ports:
//   clk_in, rst_in (async, active-high), rdy_in (global stall when low),
//   clear_in (synchronous flush)
//   issue_*   : issue request, operand values/tags/ready flags, immediate,
//               destination tag; issue_ready when an entry is free
//   cdb_*     : CDB_N broadcast channels, packed per channel
//   rob_head  : oldest in-flight RoB tag (age reference)
//   alu_*     : selected entry fields with valid/ready handshake
//   count     : number of busy entries
module rs_multi_cdb #(
    parameter int BITS     = 4,
    parameter int ROB_BITS = 4,
    parameter int CDB_N    = 2
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic                      clear_in,
    input  logic                      issue_valid,
    output logic                      issue_ready,
    input  logic [5:0]                issue_op,
    input  logic [ROB_BITS-1:0]       issue_dest,
    input  logic [31:0]               issue_vj,
    input  logic [31:0]               issue_vk,
    input  logic [ROB_BITS-1:0]       issue_qj,
    input  logic [ROB_BITS-1:0]       issue_qk,
    input  logic                      issue_rj,
    input  logic                      issue_rk,
    input  logic [31:0]               issue_imm,
    input  logic [CDB_N-1:0]          cdb_valid,
    input  logic [CDB_N*ROB_BITS-1:0] cdb_tag,
    input  logic [CDB_N*32-1:0]       cdb_value,
    input  logic [ROB_BITS-1:0]       rob_head,
    output logic                      alu_valid,
    input  logic                      alu_ready,
    output logic [5:0]                alu_op,
    output logic [31:0]               alu_vj,
    output logic [31:0]               alu_vk,
    output logic [31:0]               alu_imm,
    output logic [ROB_BITS-1:0]       alu_dest,
    output logic [BITS:0]             count
);

    localparam int            SIZE   = 1 << BITS;
    localparam logic [BITS:0] SIZE_C = (BITS+1)'(SIZE);

    // Control state (reset) and per-entry payload (not reset).
    logic [SIZE-1:0]     busy_q, busy_d;
    logic [BITS:0]       count_q, count_d;
    logic                hold_q, hold_d;
    logic [BITS-1:0]     hold_idx_q, hold_idx_d;

    logic [SIZE-1:0]     rj_q, rj_d, rk_q, rk_d;
    logic [31:0]         vj_q [SIZE];
    logic [31:0]         vj_d [SIZE];
    logic [31:0]         vk_q [SIZE];
    logic [31:0]         vk_d [SIZE];
    logic [31:0]         imm_q [SIZE];
    logic [31:0]         imm_d [SIZE];
    logic [ROB_BITS-1:0] qj_q [SIZE];
    logic [ROB_BITS-1:0] qj_d [SIZE];
    logic [ROB_BITS-1:0] qk_q [SIZE];
    logic [ROB_BITS-1:0] qk_d [SIZE];
    logic [ROB_BITS-1:0] dest_q [SIZE];
    logic [ROB_BITS-1:0] dest_d [SIZE];
    logic [5:0]          op_q [SIZE];
    logic [5:0]          op_d [SIZE];

    logic [SIZE-1:0]     eligible;
    logic [BITS-1:0]     free_idx;
    logic [BITS-1:0]     sel_idx;
    logic                issue_fire;
    logic                dispatch_fire;

    // Only registered ready flags count, so anything written this cycle
    // (issue, bypass or wakeup) becomes eligible at the earliest next cycle.
    assign eligible      = busy_q & rj_q & rk_q;
    assign issue_ready   = rdy_in && (count_q < SIZE_C);
    assign issue_fire    = issue_valid && issue_ready;
    assign alu_valid     = rdy_in && (|eligible);
    assign dispatch_fire = alu_valid && alu_ready;
    assign count         = count_q;

    assign alu_op   = op_q[sel_idx];
    assign alu_vj   = vj_q[sel_idx];
    assign alu_vk   = vk_q[sel_idx];
    assign alu_imm  = imm_q[sel_idx];
    assign alu_dest = dest_q[sel_idx];

    // Lowest-index free slot; a slot freed by this cycle's dispatch is still
    // busy in busy_q and therefore cannot be reused in the same cycle.
    always_comb begin
        free_idx = '0;
        for (int i = SIZE - 1; i >= 0; i--) begin
            if (!busy_q[i]) free_idx = BITS'(i);
        end
    end

`ifdef RS_OLDEST_FIRST_EN
    // Age is the tag distance from rob_head, wrapping mod 2^ROB_BITS.
    always_comb begin
        logic                found;
        logic [ROB_BITS-1:0] best_age;
        logic [ROB_BITS-1:0] age;
        sel_idx  = hold_idx_q;
        found    = hold_q && eligible[hold_idx_q];
        best_age = dest_q[hold_idx_q] - rob_head;
        age      = '0;
        for (int i = 0; i < SIZE; i++) begin
            age = dest_q[i] - rob_head;
            if (eligible[i] && (!found || age < best_age)) begin
                found    = 1'b1;
                best_age = age;
                sel_idx  = BITS'(i);
            end
        end
    end
`else
    // A stalled offer stays put even if a lower index wakes up meanwhile.
    always_comb begin
        sel_idx = '0;
        for (int i = SIZE - 1; i >= 0; i--) begin
            if (eligible[i]) sel_idx = BITS'(i);
        end
        if (hold_q && eligible[hold_idx_q]) sel_idx = hold_idx_q;
    end

    logic rob_head_unused;
    assign rob_head_unused = ^rob_head;
`endif

    always_comb begin
        // NOTE: every next-state variable is defaulted to its current value first,
        // so no path through this block can infer a latch.
        busy_d     = busy_q;
        count_d    = count_q;
        hold_d     = hold_q;
        hold_idx_d = hold_idx_q;
        rj_d       = rj_q;
        rk_d       = rk_q;
        vj_d       = vj_q;
        vk_d       = vk_q;
        imm_d      = imm_q;
        qj_d       = qj_q;
        qk_d       = qk_q;
        dest_d     = dest_q;
        op_d       = op_q;

        if (clear_in) begin
            busy_d  = '0;
            count_d = '0;
            hold_d  = 1'b0;
        end else if (rdy_in) begin
            // Wakeup: channels scanned high to low so the lowest channel wins.
            for (int i = 0; i < SIZE; i++) begin
                for (int c = CDB_N - 1; c >= 0; c--) begin
                    if (busy_q[i] && !rj_q[i] && cdb_valid[c]
                        && cdb_tag[c*ROB_BITS +: ROB_BITS] == qj_q[i]) begin
                        rj_d[i] = 1'b1;
                        vj_d[i] = cdb_value[c*32 +: 32];
                    end
                    if (busy_q[i] && !rk_q[i] && cdb_valid[c]
                        && cdb_tag[c*ROB_BITS +: ROB_BITS] == qk_q[i]) begin
                        rk_d[i] = 1'b1;
                        vk_d[i] = cdb_value[c*32 +: 32];
                    end
                end
            end

            if (dispatch_fire) busy_d[sel_idx] = 1'b0;

            if (issue_fire) begin
                busy_d[free_idx] = 1'b1;
                op_d[free_idx]   = issue_op;
                dest_d[free_idx] = issue_dest;
                imm_d[free_idx]  = issue_imm;
                qj_d[free_idx]   = issue_qj;
                qk_d[free_idx]   = issue_qk;
                rj_d[free_idx]   = issue_rj;
                rk_d[free_idx]   = issue_rk;
                vj_d[free_idx]   = issue_vj;
                vk_d[free_idx]   = issue_vk;
                // Bypass a producer that broadcasts in the issue cycle itself;
                // otherwise that result would never be seen by the entry.
                for (int c = CDB_N - 1; c >= 0; c--) begin
                    if (!issue_rj && cdb_valid[c]
                        && cdb_tag[c*ROB_BITS +: ROB_BITS] == issue_qj) begin
                        rj_d[free_idx] = 1'b1;
                        vj_d[free_idx] = cdb_value[c*32 +: 32];
                    end
                    if (!issue_rk && cdb_valid[c]
                        && cdb_tag[c*ROB_BITS +: ROB_BITS] == issue_qk) begin
                        rk_d[free_idx] = 1'b1;
                        vk_d[free_idx] = cdb_value[c*32 +: 32];
                    end
                end
            end

            count_d    = count_q + (BITS+1)'(issue_fire) - (BITS+1)'(dispatch_fire);
            hold_d     = alu_valid && !alu_ready;
            hold_idx_d = sel_idx;
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every flop samples the values from before the edge.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy_q     <= '0;
            count_q    <= '0;
            hold_q     <= 1'b0;
            hold_idx_q <= '0;
        end else begin
            busy_q     <= busy_d;
            count_q    <= count_d;
            hold_q     <= hold_d;
            hold_idx_q <= hold_idx_d;
        end
    end

    // NOTE: the entry payload is deliberately not reset; busy_q gates every
    // use of it, so stale contents of a free slot are never observed.
    always_ff @(posedge clk_in) begin
        rj_q   <= rj_d;
        rk_q   <= rk_d;
        vj_q   <= vj_d;
        vk_q   <= vk_d;
        imm_q  <= imm_d;
        qj_q   <= qj_d;
        qk_q   <= qk_d;
        dest_q <= dest_d;
        op_q   <= op_d;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            assert (count_q <= SIZE_C);
            assert (!(dispatch_fire && count_q == '0));
        end
    end
`endif

endmodule
